// File: rtl/alu_share_pkg.sv
// Shared types for the two-port ALU sharing arbiter.
package alu_share_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [ALU_W-1:0] op;
    logic             m;
    logic             cin;
  } alu_opnd_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_vld_o = |elig_i;
    gnt_idx_o = (&elig_i) ? ~last_i : elig_i[1];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters: grant, hold operands HOLD_CYCLES, capture, acknowledge.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [ALU_W-1:0] a0_i,
  input  logic [ALU_W-1:0] b0_i,
  input  logic [ALU_W-1:0] a1_i,
  input  logic [ALU_W-1:0] b1_i,
  input  logic [ALU_W-1:0] op0_i,
  input  logic [ALU_W-1:0] op1_i,
  input  logic             m0_i,
  input  logic             cin0_i,
  input  logic             m1_i,
  input  logic             cin1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic [ALU_W-1:0] res0_o,
  output logic [ALU_W-1:0] res1_o,
  output logic             sign0_o,
  output logic             sign1_o,
  output logic             eq0_o,
  output logic             eq1_o,
  output logic [ALU_W-1:0] alu_a_o,
  output logic [ALU_W-1:0] alu_b_o,
  output logic [ALU_W-1:0] alu_op_o,
  output logic             alu_m_o,
  output logic             alu_cin_o,
  input  logic [ALU_W-1:0] alu_out_i,
  input  logic             alu_sign_i,
  input  logic             alu_eq_i,
  output logic             busy_o
);

  // Counter value at which the settle phase ends; 0 means go straight to capture.
  localparam logic [3:0] CntLast = 4'(HOLD_CYCLES - 1);

  state_e                      state_q, state_d;
  logic      [3:0]             cnt_q, cnt_d;
  logic                        last_q, last_d;
  logic                        gnt_q, gnt_d;
  alu_opnd_t                   alu_q, alu_d;
  logic      [1:0]             ack_q, ack_d;
  logic      [1:0][ALU_W-1:0]  res_q, res_d;
  logic      [1:0]             sign_q, sign_d;
  logic      [1:0]             eq_q, eq_d;

  logic      [1:0]             elig;
  logic                        gnt_vld;
  logic                        gnt_idx;
  alu_opnd_t                   opnd0, opnd1;

  // A port being acked this cycle still shows REQ high, so mask it for one cycle.
  assign elig  = {req1_i & ~ack_q[1], req0_i & ~ack_q[0]};
  assign opnd0 = {a0_i, b0_i, op0_i, m0_i, cin0_i};
  assign opnd1 = {a1_i, b1_i, op1_i, m1_i, cin1_i};

  rr_arb2 u_rr_arb2 (
    .elig_i    (elig),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    alu_d   = alu_q;
    ack_d   = '0;
    res_d   = res_q;
    sign_d  = sign_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          gnt_d   = gnt_idx;
          last_d  = gnt_idx;
          alu_d   = gnt_idx ? opnd1 : opnd0;
          cnt_d   = '0;
          state_d = (CntLast == 4'd0) ? StCapture : StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == CntLast) state_d = StCapture;
      end
      StCapture: begin
        res_d[gnt_q]  = alu_out_i;
        sign_d[gnt_q] = alu_sign_i;
        eq_d[gnt_q]   = alu_eq_i;
        ack_d[gnt_q]  = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      alu_q   <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      sign_q  <= '0;
      eq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      alu_q   <= alu_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      eq_q    <= eq_d;
    end
  end

  assign ack0_o    = ack_q[0];
  assign ack1_o    = ack_q[1];
  assign res0_o    = res_q[0];
  assign res1_o    = res_q[1];
  assign sign0_o   = sign_q[0];
  assign sign1_o   = sign_q[1];
  assign eq0_o     = eq_q[0];
  assign eq1_o     = eq_q[1];
  assign alu_a_o   = alu_q.a;
  assign alu_b_o   = alu_q.b;
  assign alu_op_o  = alu_q.op;
  assign alu_m_o   = alu_q.m;
  assign alu_cin_o = alu_q.cin;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: instance 0 uses HOLD_CYCLES=1, instance 1 uses HOLD_CYCLES=3.
module tb_alu_share_arb;

  typedef struct {
    int res;
    int sgn;
    int eq;
    int t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  logic       req [2][2];
  logic       m   [2][2];
  logic       cin [2][2];
  logic [3:0] a   [2][2];
  logic [3:0] b   [2][2];
  logic [3:0] op  [2][2];
  logic       ack [2][2];
  logic       sgn [2][2];
  logic       eq  [2][2];
  logic [3:0] res [2][2];
  logic [3:0] alu_a [2];
  logic [3:0] alu_b [2];
  logic [3:0] alu_op [2];
  logic [3:0] alu_out [2];
  logic       alu_m [2];
  logic       alu_cin [2];
  logic       alu_sign [2];
  logic       alu_eq [2];
  logic       busy [2];

  exp_t       sbq [4][$];
  int         exp_res [2][2];
  logic [3:0] last_op [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_arb #(
      .HOLD_CYCLES((g == 0) ? 1 : 3)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req0_i     (req[g][0]),
      .req1_i     (req[g][1]),
      .a0_i       (a[g][0]),
      .b0_i       (b[g][0]),
      .a1_i       (a[g][1]),
      .b1_i       (b[g][1]),
      .op0_i      (op[g][0]),
      .op1_i      (op[g][1]),
      .m0_i       (m[g][0]),
      .cin0_i     (cin[g][0]),
      .m1_i       (m[g][1]),
      .cin1_i     (cin[g][1]),
      .ack0_o     (ack[g][0]),
      .ack1_o     (ack[g][1]),
      .res0_o     (res[g][0]),
      .res1_o     (res[g][1]),
      .sign0_o    (sgn[g][0]),
      .sign1_o    (sgn[g][1]),
      .eq0_o      (eq[g][0]),
      .eq1_o      (eq[g][1]),
      .alu_a_o    (alu_a[g]),
      .alu_b_o    (alu_b[g]),
      .alu_op_o   (alu_op[g]),
      .alu_m_o    (alu_m[g]),
      .alu_cin_o  (alu_cin[g]),
      .alu_out_i  (alu_out[g]),
      .alu_sign_i (alu_sign[g]),
      .alu_eq_i   (alu_eq[g]),
      .busy_o     (busy[g])
    );

    // ALU stub: 4-bit add with sign and equality flags.
    assign alu_out[g]  = alu_a[g] + alu_b[g];
    assign alu_sign[g] = alu_out[g][3];
    assign alu_eq[g]   = (alu_a[g] == alu_b[g]);

    for (genvar p = 0; p < 2; p++) begin : g_mon
      exp_t e;
      always @(negedge clk) begin
        if (rst_n && ack[g][p]) begin
          if (sbq[g*2+p].size() == 0) begin
            check($sformatf("spurious_ack d%0d p%0d", g, p), 1, 0);
          end else begin
            e = sbq[g*2+p].pop_front();
            check($sformatf("res d%0d p%0d", g, p), int'(res[g][p]), e.res);
            check($sformatf("sign d%0d p%0d", g, p), int'(sgn[g][p]), e.sgn);
            check($sformatf("eq d%0d p%0d", g, p), int'(eq[g][p]), e.eq);
            if (e.t >= 0) check($sformatf("ack_cycle d%0d p%0d", g, p), cyc, e.t);
            exp_res[g][p] = e.res;
          end
        end
      end
    end
  end

  // Issue cnt transactions on one port, holding REQ until each ACK; exp0<0 skips timing checks.
  task automatic run_port(input int k, input int p, input int cnt, input int exp0,
                          input int stride, input int af, input int bf, input int gap);
    exp_t       e;
    int         w;
    int         g;
    logic [3:0] av, bv, s;
    for (int i = 0; i < cnt; i++) begin
      av = (af < 0) ? 4'($urandom_range(0, 15)) : 4'(af);
      bv = (bf < 0) ? 4'($urandom_range(0, 15)) : 4'(bf);
      s  = av + bv;
      a[k][p]   = av;
      b[k][p]   = bv;
      op[k][p]  = 4'($urandom_range(0, 15));
      m[k][p]   = 1'($urandom_range(0, 1));
      cin[k][p] = 1'($urandom_range(0, 1));
      last_op[k] = op[k][p];
      req[k][p] = 1'b1;
      e.res = int'(s);
      e.sgn = int'(s[3]);
      e.eq  = int'(av == bv);
      e.t   = (exp0 < 0) ? -1 : exp0 + i * stride;
      sbq[k*2+p].push_back(e);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!ack[k][p] && w < 100);
      if (!ack[k][p]) begin
        check($sformatf("ack_timeout d%0d p%0d", k, p), 0, 1);
        break;
      end
      if (gap > 0 && i < cnt - 1) begin
        g = $urandom_range(0, gap);
        if (g > 0) begin
          req[k][p] = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
    end
    req[k][p] = 1'b0;
  endtask

  task automatic check_zero(input int k, input string tag);
    check($sformatf("%s busy d%0d", tag, k), int'(busy[k]), 0);
    check($sformatf("%s alu_a d%0d", tag, k), int'(alu_a[k]), 0);
    check($sformatf("%s alu_b d%0d", tag, k), int'(alu_b[k]), 0);
    check($sformatf("%s alu_op d%0d", tag, k), int'(alu_op[k]), 0);
    check($sformatf("%s alu_m_cin d%0d", tag, k), int'({alu_m[k], alu_cin[k]}), 0);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s ack d%0d p%0d", tag, k, p), int'(ack[k][p]), 0);
      check($sformatf("%s res d%0d p%0d", tag, k, p), int'(res[k][p]), 0);
      check($sformatf("%s flags d%0d p%0d", tag, k, p), int'({sgn[k][p], eq[k][p]}), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; a[k][p] = '0; b[k][p] = '0; op[k][p] = '0;
        m[k][p] = 1'b0; cin[k][p] = 1'b0; exp_res[k][p] = 0;
      end
    end
    repeat (2) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests after reset: port 0 first, port 1 granted in the ACK0 cycle.
    n = cyc;
    fork
      run_port(0, 0, 1, n + 2, 0, 2, 9, 0);
      run_port(0, 1, 1, n + 4, 0, 7, 7, 0);
    join
    @(negedge clk);

    // Lone request, HOLD_CYCLES=1.
    n = cyc;
    fork
      run_port(0, 0, 1, n + 2, 0, 5, 3, 0);
      begin
        @(negedge clk);
        check("t1 alu_a", int'(alu_a[0]), 5);
        check("t1 alu_b", int'(alu_b[0]), 3);
        check("t1 alu_op", int'(alu_op[0]), int'(last_op[0]));
        check("t1 busy", int'(busy[0]), 1);
      end
    join
    @(negedge clk);

    // Both held for six transactions; port 0 won last, so port 1 leads.
    n = cyc;
    fork
      run_port(0, 0, 3, n + 4, 4, -1, -1, 0);
      run_port(0, 1, 3, n + 2, 4, -1, -1, 0);
    join
    @(negedge clk);

    // Port 1 raises and withdraws while port 0 is busy: never served.
    n  = cyc;
    r1 = exp_res[0][1];
    fork
      run_port(0, 0, 1, n + 2, 0, -1, -1, 0);
      begin
        @(negedge clk);
        a[0][1] = 4'd1; b[0][1] = 4'd1; req[0][1] = 1'b1;
        @(negedge clk);
        req[0][1] = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("withdraw res1 kept", int'(res[0][1]), r1);
    check("withdraw busy", int'(busy[0]), 0);

    // HOLD_CYCLES=3, lone port 1: operands stable three cycles, ACK after four.
    n = cyc;
    fork
      run_port(1, 1, 1, n + 4, 0, 9, 4, 0);
      begin
        for (int i = 1; i <= 3; i++) begin
          @(negedge clk);
          check($sformatf("t6 alu_a c%0d", i), int'(alu_a[1]), 9);
          check($sformatf("t6 alu_b c%0d", i), int'(alu_b[1]), 4);
          check($sformatf("t6 busy c%0d", i), int'(busy[1]), 1);
        end
        @(negedge clk);
        check("t6 busy after", int'(busy[1]), 0);
      end
    join
    @(negedge clk);

    // Reset pulsed during SETTLE drops the transaction.
    req[1][0] = 1'b1; a[1][0] = 4'd6; b[1][0] = 4'd2;
    repeat (2) @(negedge clk);
    check("t7 busy before reset", int'(busy[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(1, "midreset");
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) exp_res[k][p] = 0;
    req[1][0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n = cyc;
    run_port(1, 0, 1, n + 4, 0, 6, 2, 0);
    @(negedge clk);

    // Random traffic on both instances, data checked through the scoreboard.
    fork
      run_port(0, 0, 8, -1, 0, -1, -1, 3);
      run_port(0, 1, 8, -1, 0, -1, -1, 3);
      run_port(1, 0, 8, -1, 0, -1, -1, 3);
      run_port(1, 1, 8, -1, 0, -1, -1, 3);
    join
    repeat (6) @(negedge clk);
    for (int q = 0; q < 4; q++) check($sformatf("sb_empty q%0d", q), sbq[q].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
